fwd_hazard_ctrl: RTL and testbench
==================================

FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on the rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 id_valid  in  1  ID stage holds a real instruction.
REQ-004 id_rs, id_rt  in  5 each  ID source register numbers.
REQ-005 id_uses_rs, id_uses_rt  in  1 each  ID instruction reads that source.
REQ-006 id_rd  in  5  ID destination register, already muxed rt/rd.
REQ-007 id_regwrite, id_memread  in  1 each  ID instruction writes a register / is a load.
REQ-008 flush  in  1  branch/jump resolved taken; kills the ID instruction.
REQ-009 pipe_hold  in  1  global freeze, e.g. memory wait.
REQ-010 forwardA, forwardB  out  2 each  registered EX-stage ALU operand selects: 00 register file, 10 EX/MEM ALU result, 01 MEM/WB write data; 11 never driven.
REQ-011 stall  out  1  combinational; hold PC and IF/ID.
REQ-012 bubble  out  1  combinational; load a NOP into ID/EX.
REQ-013 stall_count  out  32  load-use stall cycles; present only under FWD_STALL_CNT_EN.

Function
REQ-014 A 2-entry shadow pipeline SHALL hold {valid, rd, regwrite, memread}: EX entry and MEM entry.
REQ-015 Each non-held, non-stalled edge: MEM <- EX; EX <- ID fields, with valid = id_valid & ~flush.
REQ-016 On a bubble edge: MEM <- EX; EX <- invalid.
REQ-017 Match(entry, src) = entry.valid & entry.regwrite & entry.rd != 0 & entry.rd == src & uses_src.
REQ-018 Next forwardA = 10 if Match(EX, id_rs); else 01 if Match(MEM, id_rs); else 00. forwardB uses id_rt in the same way. EX priority gives the newest value.
REQ-019 forwardA/B SHALL register on the same edge that moves ID into EX, so they align with the ID/EX operands. They SHALL be 00 on bubble or flush edges.
REQ-020 Load-use hazard = id_valid & ~flush & EX.memread & (Match(EX, id_rs) | Match(EX, id_rt)).
REQ-021 FSM states: RUN and LU_STALL.
REQ-022 RUN -> LU_STALL on load-use hazard. In this transition cycle, stall = bubble = 1.
REQ-023 LU_STALL -> RUN unconditionally on the next non-held edge, with stall = bubble = 0. The load is now in MEM, so the held instruction gets a 01 select.
REQ-024 pipe_hold = 1 freezes FSM, shadow entries, forwardA/B, and the counter. stall = bubble = 0 while held.
REQ-025 flush in any state SHALL suppress load-use detection, force the next state to RUN, and deassert stall.
REQ-026 Register 0 SHALL never produce a forward or a stall.
REQ-027 Back-to-back load-use hazards SHALL each cost exactly one stall cycle.

Reset
REQ-028 On reset, both shadow entries are invalid, the FSM is in RUN, forwardA = forwardB = 00, and stall_count = 0.
REQ-029 Reset overrides pipe_hold and flush. A reset during LU_STALL returns to RUN with no residual stall.

Configuration
REQ-030 Macro FWD_STALL_CNT_EN defined: the stall_count port exists and increments once per RUN -> LU_STALL transition. It saturates at 0xFFFFFFFF.
REQ-031 Macro undefined: no stall_count port and no counter logic. All other behaviour is identical.

Structure
REQ-032 The shared package SHALL hold the forward-select constants FWD_RF = 00, FWD_EXMEM = 10, FWD_MEMWB = 01, the FSM state encoding, and the shadow-entry typedef.
REQ-033 One sub-module, fwd_match, SHALL implement REQ-017 and be instantiated once per entry/source pair, four instances total.

Verification
REQ-034 add $3 <- $1,$2, then sub $4 <- $3,$5 -> on the sub's EX cycle, forwardA = 10, forwardB = 00, and stall never asserts.
REQ-035 add $3, an independent instruction, then or $6 <- $7,$3 -> forwardB = 01 on the or's EX cycle.
REQ-036 lw $8, then add $9 <- $8,$8 -> stall = bubble = 1 for exactly 1 cycle, the next EX cycle has a bubble, and the add then gets forwardA = forwardB = 01. stall_count = 1 under the macro.
REQ-037 Instruction writing $0, then a consumer of $0 -> forwardA/B = 00 and no stall.
REQ-038 lw $8 followed by a use of $8 with flush = 1 in the same cycle -> stall = 0, EX entry invalid, state RUN.
REQ-039 pipe_hold = 1 for 3 cycles during LU_STALL -> outputs and state are frozen, and the machine resumes to RUN on the first cycle after hold drops.

Source files
------------

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types and constants for the forwarding / load-use hazard controller.
package fwd_hazard_ctrl_pkg;

  // EX-stage ALU operand selects
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_t;

  // One slot of the shadow pipeline (EX or MEM)
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } shadow_t;

  localparam shadow_t SHADOW_EMPTY = '0;

  // EX hit wins over MEM hit so the newest value is forwarded
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
    if (ex_hit)       return FWD_EXMEM;
    else if (mem_hit) return FWD_MEMWB;
    else              return FWD_RF;
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage request / EX-stage select bundle between the pipeline and the hazard controller.
interface fwd_hazard_ctrl_if;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic       flush;
  logic       pipe_hold;
  logic [1:0] forwardA;
  logic [1:0] forwardB;
  logic       stall;
  logic       bubble;

  // Pipeline side: supplies ID info, consumes selects and stall controls
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_regwrite, id_memread, flush, pipe_hold,
    input  forwardA, forwardB, stall, bubble
  );

  // Controller side
  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_regwrite, id_memread, flush, pipe_hold,
    output forwardA, forwardB, stall, bubble
  );
endinterface

// File: rtl/fwd_hazard_ctrl_match.sv
// Single dependency check of one shadow entry against one ID source register.
module fwd_match
  import fwd_hazard_ctrl_pkg::*;
(
  input  shadow_t    entry_i,
  input  logic [4:0] src_i,
  input  logic       uses_i,
  output logic       match_o
);

  // $0 is hard-wired zero, so it never matches
  always_comb begin
    match_o = entry_i.valid & entry_i.regwrite & (entry_i.rd != 5'd0) &
              (entry_i.rd == src_i) & uses_i;
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall controller for a 5-stage pipeline.
// Optional feature: define FWD_STALL_CNT_EN to add the saturating stall_count output.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  fwd_hazard_ctrl_if.slave bus
`ifdef FWD_STALL_CNT_EN
  ,output logic [31:0] stall_count
`endif
);

  state_t     state_q, state_d;
  shadow_t    ex_q, ex_d;
  shadow_t    mem_q, mem_d;
  logic [1:0] fwd_a_q, fwd_a_d;
  logic [1:0] fwd_b_q, fwd_b_d;
  logic       stall_c, bubble_c;
  logic       ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit;
  logic       load_use;

  fwd_match u_ex_rs (.entry_i(ex_q),  .src_i(bus.id_rs), .uses_i(bus.id_uses_rs), .match_o(ex_rs_hit));
  fwd_match u_ex_rt (.entry_i(ex_q),  .src_i(bus.id_rt), .uses_i(bus.id_uses_rt), .match_o(ex_rt_hit));
  fwd_match u_mem_rs(.entry_i(mem_q), .src_i(bus.id_rs), .uses_i(bus.id_uses_rs), .match_o(mem_rs_hit));
  fwd_match u_mem_rt(.entry_i(mem_q), .src_i(bus.id_rt), .uses_i(bus.id_uses_rt), .match_o(mem_rt_hit));

  // Load in EX feeding the ID instruction; a flush kills the consumer so no hazard
  always_comb begin
    load_use = bus.id_valid & ~bus.flush & ex_q.memread & (ex_rs_hit | ex_rt_hit);
  end

  // Next-state, shadow advance, select computation and stall/bubble outputs
  always_comb begin
    state_d  = state_q;
    ex_d     = ex_q;
    mem_d    = mem_q;
    fwd_a_d  = fwd_a_q;
    fwd_b_d  = fwd_b_q;
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    if (!reset && !bus.pipe_hold) begin
      mem_d = ex_q;
      if (state_q == RUN && load_use) begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
        ex_d     = SHADOW_EMPTY;
        fwd_a_d  = FWD_RF;
        fwd_b_d  = FWD_RF;
        state_d  = LU_STALL;
      end else begin
        // LU_STALL always releases here; EX is the bubble, so the load now sits in MEM
        ex_d.valid    = bus.id_valid & ~bus.flush;
        ex_d.rd       = bus.id_rd;
        ex_d.regwrite = bus.id_regwrite;
        ex_d.memread  = bus.id_memread;
        fwd_a_d       = bus.flush ? FWD_RF : fwd_sel(ex_rs_hit, mem_rs_hit);
        fwd_b_d       = bus.flush ? FWD_RF : fwd_sel(ex_rt_hit, mem_rt_hit);
        state_d       = RUN;
      end
    end
  end

  // State, shadow pipeline and registered selects
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      ex_q    <= SHADOW_EMPTY;
      mem_q   <= SHADOW_EMPTY;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign bus.forwardA = fwd_a_q;
  assign bus.forwardB = fwd_b_q;
  assign bus.stall    = stall_c;
  assign bus.bubble   = bubble_c;

`ifdef FWD_STALL_CNT_EN
  logic [31:0] cnt_q;

  // One count per RUN -> LU_STALL transition, i.e. per bubble edge; saturates
  always_ff @(posedge clk) begin
    if (reset)                          cnt_q <= '0;
    else if (bubble_c && cnt_q != '1)   cnt_q <= cnt_q + 32'd1;
  end

  assign stall_count = cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fwd_hazard_ctrl_if bus();

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_count;
  fwd_hazard_ctrl dut (.clk(clk), .reset(reset), .bus(bus), .stall_count(stall_count));
`else
  fwd_hazard_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  // ---------------- reference model ----------------
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       rw;
    bit       mr;
  } rec_t;

  typedef struct {
    bit        chk;
    bit        stall;
    bit [1:0]  fa;
    bit [1:0]  fb;
    bit [31:0] cnt;
  } exp_t;

  typedef struct {
    bit       v;
    bit [4:0] rs, rt;
    bit       urs, urt;
    bit [4:0] rd;
    bit       rw, mr;
  } ins_t;

  rec_t      hist[$];      // instructions that entered EX, newest first
  bit        waiting;      // consumer currently held behind a load
  bit [1:0]  m_fa, m_fb;
  bit [31:0] m_cnt;
  bit        known;        // a reset edge has happened
  exp_t      sb[$];

  int unsigned checks = 0;
  int unsigned passed = 0;

  function automatic bit [1:0] model_sel(bit [4:0] src, bit uses);
    for (int i = 0; i < 2; i++)
      if (uses && hist[i].v && hist[i].rw && hist[i].rd != 0 && hist[i].rd == src)
        return (i == 0) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Apply one cycle of inputs, record expectation, advance model across the edge
  task automatic drive(input ins_t in, input bit fl, input bit hd, input bit rst);
    exp_t e;
    rec_t nr;
    rec_t inv;
    bit [1:0] na, nb;
    @(posedge clk); #1;
    bus.id_valid = in.v;   bus.id_rs = in.rs;       bus.id_rt = in.rt;
    bus.id_uses_rs = in.urs; bus.id_uses_rt = in.urt; bus.id_rd = in.rd;
    bus.id_regwrite = in.rw; bus.id_memread = in.mr;
    bus.flush = fl; bus.pipe_hold = hd; reset = rst;

    inv = '{v: 1'b0, rd: 5'd0, rw: 1'b0, mr: 1'b0};
    e.chk   = known;
    e.stall = !rst && !hd && !waiting && in.v && !fl && hist[0].v && hist[0].mr &&
              hist[0].rw && hist[0].rd != 0 &&
              ((in.urs && hist[0].rd == in.rs) || (in.urt && hist[0].rd == in.rt));
    e.fa  = m_fa;
    e.fb  = m_fb;
    e.cnt = m_cnt;
    sb.push_back(e);

    if (rst) begin
      hist = '{inv, inv};
      waiting = 0; m_fa = 0; m_fb = 0; m_cnt = 0; known = 1;
    end else if (!hd) begin
      if (e.stall) begin
        hist.push_front(inv);
        m_fa = 0; m_fb = 0; waiting = 1;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
      end else begin
        na = fl ? 2'b00 : model_sel(in.rs, in.urs);
        nb = fl ? 2'b00 : model_sel(in.rt, in.urt);
        nr = '{v: in.v & ~fl, rd: in.rd, rw: in.rw, mr: in.mr};
        hist.push_front(nr);
        m_fa = na; m_fb = nb; waiting = 0;
      end
      void'(hist.pop_back());
    end
  endtask

  function automatic ins_t mk(bit [4:0] rs, bit [4:0] rt, bit [4:0] rd, bit load);
    ins_t i;
    i = '{v: 1'b1, rs: rs, rt: rt, urs: 1'b1, urt: 1'b1, rd: rd, rw: 1'b1, mr: load};
    return i;
  endfunction

  function automatic ins_t nop();
    ins_t i;
    i = '{v: 1'b0, rs: 5'd0, rt: 5'd0, urs: 1'b0, urt: 1'b0, rd: 5'd0, rw: 1'b0, mr: 1'b0};
    return i;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("stall",  {31'd0, bus.stall},  {31'd0, e.stall});
        check("bubble", {31'd0, bus.bubble}, {31'd0, e.stall});
        if (e.chk) begin
          check("forwardA", {30'd0, bus.forwardA}, {30'd0, e.fa});
          check("forwardB", {30'd0, bus.forwardB}, {30'd0, e.fb});
`ifdef FWD_STALL_CNT_EN
          check("stall_count", stall_count, e.cnt);
`endif
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    ins_t cur;
    rec_t inv;
    bit fl, hd, rs;
    inv = '{v: 1'b0, rd: 5'd0, rw: 1'b0, mr: 1'b0};
    hist = '{inv, inv};
    waiting = 0; m_fa = 0; m_fb = 0; m_cnt = 0; known = 0;
    bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
    bus.id_rd = 0; bus.id_regwrite = 0; bus.id_memread = 0; bus.flush = 0; bus.pipe_hold = 0;
    reset = 1;

    // reset also asserted with hold and flush to show it dominates
    drive(nop(), 1'b1, 1'b1, 1'b1);
    drive(nop(), 1'b0, 1'b0, 1'b1);
    drive(nop(), 1'b0, 0, 0);

    // add $3 <- $1,$2 ; sub $4 <- $3,$5
    drive(mk(1, 2, 3, 0), 0, 0, 0);
    drive(mk(3, 5, 4, 0), 0, 0, 0);
    drive(nop(), 0, 0, 0);
    drive(nop(), 0, 0, 0);

    // add $3 ; independent ; or $6 <- $7,$3
    drive(mk(1, 2, 3, 0), 0, 0, 0);
    drive(mk(10, 11, 12, 0), 0, 0, 0);
    drive(mk(7, 3, 6, 0), 0, 0, 0);
    drive(nop(), 0, 0, 0);

    // lw $8 ; add $9 <- $8,$8 (held one cycle)
    drive(mk(1, 0, 8, 1), 0, 0, 0);
    drive(mk(8, 8, 9, 0), 0, 0, 0);
    drive(mk(8, 8, 9, 0), 0, 0, 0);
    drive(nop(), 0, 0, 0);
    drive(nop(), 0, 0, 0);

    // write $0, then consume $0
    drive(mk(1, 2, 0, 1), 0, 0, 0);
    drive(mk(0, 0, 5, 0), 0, 0, 0);
    drive(nop(), 0, 0, 0);
    drive(nop(), 0, 0, 0);

    // lw $8 ; use of $8 flushed
    drive(mk(1, 0, 8, 1), 0, 0, 0);
    drive(mk(8, 2, 9, 0), 1, 0, 0);
    drive(mk(8, 2, 9, 0), 0, 0, 0);
    drive(nop(), 0, 0, 0);

    // lw $8 ; use stalls ; hold 3 cycles in LU_STALL ; release
    drive(mk(1, 0, 8, 1), 0, 0, 0);
    drive(mk(2, 8, 9, 0), 0, 0, 0);
    repeat (3) drive(mk(2, 8, 9, 0), 0, 1, 0);
    drive(mk(2, 8, 9, 0), 0, 0, 0);
    drive(nop(), 0, 0, 0);

    // back-to-back load-use chain
    drive(mk(1, 0, 4, 1), 0, 0, 0);
    drive(mk(4, 0, 5, 1), 0, 0, 0);
    drive(mk(4, 0, 5, 1), 0, 0, 0);
    drive(mk(5, 5, 6, 0), 0, 0, 0);
    drive(mk(5, 5, 6, 0), 0, 0, 0);
    drive(nop(), 0, 0, 0);

    // reset while in LU_STALL
    drive(mk(1, 0, 7, 1), 0, 0, 0);
    drive(mk(7, 0, 2, 0), 0, 0, 0);
    drive(mk(7, 0, 2, 0), 0, 0, 1);
    drive(mk(7, 0, 2, 0), 0, 0, 0);
    drive(nop(), 0, 0, 0);

    // randomized traffic; ID is held while the model is stalled or frozen
    cur = nop();
    hd  = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!(waiting || hd)) begin
        cur.v   = ($urandom_range(0, 9) != 0);
        cur.rs  = 5'($urandom_range(0, 7));
        cur.rt  = 5'($urandom_range(0, 7));
        cur.urs = ($urandom_range(0, 5) != 0);
        cur.urt = ($urandom_range(0, 2) != 0);
        cur.rd  = 5'($urandom_range(0, 7));
        cur.rw  = ($urandom_range(0, 4) != 0);
        cur.mr  = cur.rw && ($urandom_range(0, 2) == 0);
      end
      fl = ($urandom_range(0, 11) == 0);
      hd = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 99) == 0);
      drive(cur, fl, hd, rs);
    end

    // let the monitor drain, bounded
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
    @(negedge clk); #1;
    if (sb.size() != 0) check("drain", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
